uart_autobaud_ctrl: RTL and testbench
=====================================

Name: uart_autobaud_ctrl

Overview:
- Configuration controller for the UART baud clock generator.
- When armed, measures a host-sent 0x55 sync character on the rx pin and computes the 13-bit divide value and 3-bit eighth-fraction that the generator needs.
- Holds that configuration on its outputs until the next successful detection.
- Sits between the APB register block (arm/abort/status) and the baud generator's baud_val / BAUD_VAL_FRACTION inputs; intended for a build with fractional baud enabled.

Parameters:
- CNT_W, 20, width of the interval counter; must be ≥ 8, covers baud_val (13) + 7 fractional bits.
- DEFAULT_BAUD_VAL, 13'd0, baud_val output after reset.
- DEFAULT_FRACTION, 3'd0, baud_val_fraction output after reset.
- IDLE_CYCLES, 16, consecutive clk cycles rx must be high after arming before a start edge is accepted.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- rx  in  1  asynchronous serial input (pin)
- arm  in  1  1-cycle pulse: start a detection
- abort  in  1  1-cycle pulse: cancel a detection
- busy  out  1  detection in progress
- done  out  1  1-cycle pulse: new configuration loaded
- err  out  1  1-cycle pulse: detection failed
- err_code  out  2  00 none, 01 overflow, 10 too fast, 11 interval check fail; holds until next arm
- baud_val  out  13  divide value to the baud generator
- baud_val_fraction  out  3  eighth-cycle fraction to the baud generator

Behaviour:
- Reset reset_n, asynchronous, active-low; clock clk.
- Reset values:
  - busy=0, done=0, err=0, err_code=00.
  - baud_val=DEFAULT_BAUD_VAL, baud_val_fraction=DEFAULT_FRACTION.
  - Synchronizer flops=1, FSM=IDLE.
- rx passes through a 2-flop synchronizer. A falling edge is detected as synced prev=1 & synced cur=0. Every edge sees the same latency, so measurement is exact.
- 0x55 sent LSB-first has falling edges at bit times 0, 2, 4, 6, 8. The interval from the first to the fifth detected falling edge is T = 8 bit periods.
- FSM states:
  - IDLE: busy=0. On arm → QUIET; clear err_code; load the quiet counter.
  - QUIET: rx low resets the quiet counter. After IDLE_CYCLES consecutive high cycles → WAIT_START.
  - WAIT_START: no timeout. On falling edge → MEASURE; cnt=1; edge_cnt=1.
  - MEASURE:
    - cnt increments each cycle, saturating at all-ones.
    - Each falling edge increments edge_cnt. On edge_cnt reaching 5, T=cnt at that detection cycle → CALC.
    - If cnt reaches all-ones → ERR, code 01.
  - CALC (1 cycle):
    - q = T[CNT_W-1:7], f = T[6:4].
    - If q==0 → ERR, code 10.
    - Else baud_val = q-1 (truncated to 13 bits; q > 8192 saturates baud_val to 8191, f forced to 7), baud_val_fraction = f.
    - Then DONE.
  - DONE: done=1 for 1 cycle → IDLE.
  - ERR: err=1 for 1 cycle, err_code latched, outputs unchanged → IDLE.
- busy=1 in every state except IDLE.
- abort in any non-IDLE state → IDLE next cycle. No done/err pulse, outputs unchanged, err_code unchanged.
- arm while busy is ignored. arm and abort in the same cycle: abort wins.
- baud_val / baud_val_fraction change only on the CALC→DONE transition, and both update in the same cycle.
- Latency: done asserts 2 cycles after the fifth falling edge is detected (CALC, then DONE).

Optional Feature:
- Macro AUTOBAUD_CHECK_EN.
- When defined:
  - The four falling-to-falling intervals I1..I4 are each captured (CNT_W bits).
  - In CALC, any |Ik·4 − T| > T/8 (i.e. Ik deviates from T/4 by more than T/32) → ERR, code 11.
  - The check adds one extra CALC cycle, so done latency becomes 3.
- When undefined: no interval registers, code 11 is never produced, latency 2.

Test Plan:
- Reset → baud_val=DEFAULT_BAUD_VAL, baud_val_fraction=DEFAULT_FRACTION, busy=0, err_code=00, done=0.
- arm, then 0x55 at 160 clk/bit → T=1280 → done pulse, baud_val=9, baud_val_fraction=0.
- arm, then 0x55 at 164 clk/bit → T=1312 → baud_val=9, baud_val_fraction=2.
- arm, then 0x55 at 12 clk/bit → T=96 → err pulse, err_code=10, baud_val unchanged.
- arm, single falling edge, rx held low → after 2^20−1 cycles err pulse, err_code=01. Separately: abort after the 3rd edge → busy=0 next cycle, no done/err, outputs unchanged.
- With AUTOBAUD_CHECK_EN: 0x55 at 160 clk/bit with the second 2-bit interval stretched to 400 clk → err_code=11, outputs unchanged.

Source files
------------

// File: rtl/uart_autobaud_ctrl_if.sv
// uart_autobaud_ctrl_if: control/status and baud configuration bundle between the register block and uart_autobaud_ctrl
// master: register-block side (drives arm/abort, observes status and configuration)
// slave:  controller side (receives arm/abort, drives status and configuration)
interface uart_autobaud_ctrl_if;
  logic        arm;
  logic        abort;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [12:0] baud_val;
  logic [2:0]  baud_val_fraction;
  modport master (
    output arm, abort,
    input  busy, done, err, err_code, baud_val, baud_val_fraction
  );
  modport slave (
    input  arm, abort,
    output busy, done, err, err_code, baud_val, baud_val_fraction
  );
endinterface

// File: rtl/uart_autobaud_ctrl.sv
// uart_autobaud_ctrl: measures a 0x55 sync character on rx and loads baud_val/baud_val_fraction for the baud generator
// Ports: clk; reset_n (async, active-low); rx (asynchronous pin);
//        io (slave): arm/abort pulses in; busy, done/err pulses, err_code, baud_val, baud_val_fraction out.
// Optional: define AUTOBAUD_CHECK_EN to capture the four edge-to-edge intervals and reject
//           inconsistent sync characters (err_code 11); this adds one calc cycle.
module uart_autobaud_ctrl #(
  parameter int          CNT_W            = 20,
  parameter logic [12:0] DEFAULT_BAUD_VAL = 13'd0,
  parameter logic [2:0]  DEFAULT_FRACTION = 3'd0,
  parameter int          IDLE_CYCLES      = 16
) (
  input logic              clk,
  input logic              reset_n,
  input logic              rx,
  uart_autobaud_ctrl_if.slave io
);
  localparam int QW = $clog2(IDLE_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, QUIET, WAIT_START, MEASURE, CALC, CHECK, DONE, ERR} state_t;
`ifdef AUTOBAUD_CHECK_EN
  localparam int     TL    = 0;
  localparam state_t FINAL = CHECK;
`else
  localparam int     TL    = 4;
  localparam state_t FINAL = CALC;
`endif
  state_t state, state_nxt;
  logic [1:0] sync;
  logic rx_prev, fall, chk_bad, bad;
  logic [QW-1:0] qcnt;
  logic [CNT_W-1:0] cnt;
  logic [2:0] edge_cnt;
  logic [CNT_W-1:TL] t_val;
  logic [31:0] q_w;
  logic [1:0] code_q;
  logic [12:0] baud_q;
  logic [2:0] frac_q;
  // both synced samples share the same latency, so edge spacing is measured exactly
  assign fall = rx_prev & ~sync[1];
  // T = 128*q + 16*f + remainder: q whole baud periods of 16 clks, f eighths
  assign q_w = 32'(t_val[CNT_W-1:7]);
  assign bad = q_w == 32'd0 || chk_bad;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       state_nxt = (io.arm && !io.abort) ? QUIET : IDLE;
      QUIET:      state_nxt = (sync[1] && qcnt == QW'(IDLE_CYCLES - 1)) ? WAIT_START : QUIET;
      WAIT_START: state_nxt = fall ? MEASURE : WAIT_START;
      MEASURE:    state_nxt = (fall && edge_cnt == 3'd4) ? CALC : (cnt == '1) ? ERR : MEASURE;
      CALC:       state_nxt = (FINAL == CALC) ? (bad ? ERR : DONE) : CHECK;
      CHECK:      state_nxt = bad ? ERR : DONE;
      DONE:       state_nxt = IDLE;
      ERR:        state_nxt = IDLE;
    endcase
    if (io.abort && state != IDLE) state_nxt = IDLE;
  end
  assign io.busy              = state != IDLE;
  assign io.done              = state == DONE;
  assign io.err               = state == ERR;
  assign io.err_code          = code_q;
  assign io.baud_val          = baud_q;
  assign io.baud_val_fraction = frac_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync     <= 2'b11;
      rx_prev  <= 1'b1;
      qcnt     <= '0;
      cnt      <= '0;
      edge_cnt <= '0;
      t_val    <= '0;
      code_q   <= 2'b00;
      baud_q   <= DEFAULT_BAUD_VAL;
      frac_q   <= DEFAULT_FRACTION;
    end else begin
      sync     <= {sync[0], rx};
      rx_prev  <= sync[1];
      qcnt     <= (state == QUIET && sync[1]) ? qcnt + QW'(1) : '0;
      cnt      <= (state == WAIT_START) ? CNT_W'(1) : (cnt == '1) ? cnt : cnt + CNT_W'(1);
      edge_cnt <= (state == WAIT_START) ? 3'd1 : (state == MEASURE && fall) ? edge_cnt + 3'd1 : edge_cnt;
      if (state == MEASURE && fall) t_val <= cnt[CNT_W-1:TL];
      if (state == IDLE && io.arm && !io.abort) code_q <= 2'b00;
      else if (state_nxt == ERR) code_q <= (state == MEASURE) ? 2'b01 : (q_w == 32'd0) ? 2'b10 : 2'b11;
      if (state_nxt == DONE) begin
        baud_q <= (q_w > 32'd8192) ? 13'h1fff : 13'(q_w - 32'd1);
        frac_q <= (q_w > 32'd8192) ? 3'd7 : t_val[6:4];
      end
    end
`ifdef AUTOBAUD_CHECK_EN
  logic [CNT_W-1:0] last;
  logic [CNT_W-1:0] iv [4];
  logic chk_now;
  // 4*Ik vs T, tolerance T/8
  function automatic logic off(input logic [CNT_W-1:0] i, input logic [CNT_W-1:0] t);
    logic [CNT_W+1:0] a, b;
    a = {i, 2'b00};
    b = {2'b00, t};
    return ((a > b) ? a - b : b - a) > {5'b00000, t[CNT_W-1:3]};
  endfunction
  always_comb begin
    chk_now = 1'b0;
    for (int k = 0; k < 4; k++) chk_now = chk_now | off(iv[k], t_val);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      last    <= '0;
      chk_bad <= 1'b0;
      for (int k = 0; k < 4; k++) iv[k] <= '0;
    end else begin
      if (state == WAIT_START) last <= '0;
      if (state == MEASURE && fall) begin
        iv[2'(edge_cnt - 3'd1)] <= cnt - last;
        last <= cnt;
      end
      if (state == CALC) chk_bad <= chk_now;
    end
`else
  assign chk_bad = 1'b0;
`endif
endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// tb_uart_autobaud_ctrl: randomized self-checking bench for uart_autobaud_ctrl against an arithmetic model
module tb_uart_autobaud_ctrl;
  localparam int          CW  = 14;
  localparam int          IC  = 16;
  localparam logic [12:0] DBV = 13'd100;
  localparam logic [2:0]  DFR = 3'd5;
  localparam int          M   = (1 << CW) - 1;
`ifdef AUTOBAUD_CHECK_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rx = 1'b1;
  int total = 0;
  int bad = 0;
  int m_bv, m_fr, m_code;
  int dur [8];
  always #5 clk = ~clk;
  uart_autobaud_ctrl_if io();
  uart_autobaud_ctrl #(.CNT_W(CW), .DEFAULT_BAUD_VAL(DBV), .DEFAULT_FRACTION(DFR), .IDLE_CYCLES(IC)) dut (
    .clk(clk), .reset_n(reset_n), .rx(rx), .io(io)
  );
  task automatic pulse_arm(input string nm);
    @(negedge clk) io.arm = 1'b1;
    @(negedge clk) io.arm = 1'b0;
    total++;
    if (io.busy !== 1'b1 || io.err_code !== 2'b00) begin
      bad++;
      $display("FAIL %s arm: busy=%b err_code=%b expected busy=1 err_code=00", nm, io.busy, io.err_code);
    end
    repeat (IC + 8) @(negedge clk);
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (io.baud_val !== DBV || io.baud_val_fraction !== DFR) begin
      bad++;
      $display("FAIL reset cfg: baud=%0d frac=%0d expected %0d %0d", io.baud_val, io.baud_val_fraction, DBV, DFR);
    end
    total++;
    if ({io.busy, io.done, io.err, io.err_code} !== 5'b0) begin
      bad++;
      $display("FAIL reset status: busy/done/err/code=%b expected 00000", {io.busy, io.done, io.err, io.err_code});
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (io.busy !== 1'b0 || io.baud_val !== DBV || io.baud_val_fraction !== DFR) begin
      bad++;
      $display("FAIL post-reset: busy=%b baud=%0d frac=%0d expected 0 %0d %0d", io.busy, io.baud_val, io.baud_val_fraction, DBV, DFR);
    end
    m_bv = DBV;
    m_fr = DFR;
    m_code = 0;
  endtask
  // sends bits 0..7 of 0x55 framed with start bit, using dur[] clocks per bit, and checks the result
  task automatic run_frame(input string nm);
    int t, q, f, code, stray;
    logic [1:0] exp_de;
    t = 0;
    for (int i = 0; i < 8; i++) t += dur[i];
    q = t / 128;
    f = (t / 16) % 8;
    code = 0;
    if (q == 0) code = 2;
`ifdef AUTOBAUD_CHECK_EN
    else
      for (int k = 0; k < 4; k++) begin
        int dv;
        dv = 4 * (dur[2*k] + dur[2*k+1]) - t;
        if (dv < 0) dv = -dv;
        if (dv > t / 8) code = 3;
      end
`endif
    if (code == 0) begin
      m_bv = (q > 8192) ? 8191 : q - 1;
      m_fr = (q > 8192) ? 7 : f;
    end
    m_code = code;
    exp_de = (code == 0) ? 2'b10 : 2'b01;
    pulse_arm(nm);
    for (int i = 0; i < 8; i++) begin
      rx = (i % 2 == 1) ? 1'b1 : 1'b0;
      repeat (dur[i]) @(negedge clk);
    end
    rx = 1'b0;
    stray = 0;
    for (int k = 1; k <= LAT + 2; k++) begin
      @(negedge clk);
      if (k == LAT) begin
        total++;
        if ({io.done, io.err} !== exp_de) begin
          bad++;
          $display("FAIL %s pulse: done/err=%b expected %b (T=%0d)", nm, {io.done, io.err}, exp_de, t);
        end
      end else if (io.done || io.err) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL %s stray pulses: %0d expected 0", nm, stray);
    end
    total++;
    if (io.baud_val !== 13'(m_bv) || io.baud_val_fraction !== 3'(m_fr)) begin
      bad++;
      $display("FAIL %s cfg: baud=%0d frac=%0d expected %0d %0d (T=%0d)", nm, io.baud_val, io.baud_val_fraction, m_bv, m_fr, t);
    end
    total++;
    if (io.err_code !== 2'(m_code) || io.busy !== 1'b0) begin
      bad++;
      $display("FAIL %s status: err_code=%b busy=%b expected %0d 0", nm, io.err_code, io.busy, m_code);
    end
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  task automatic test_directed();
    for (int i = 0; i < 8; i++) dur[i] = 160;
    run_frame("p160");
    for (int i = 0; i < 8; i++) dur[i] = 164;
    run_frame("p164");
    for (int i = 0; i < 8; i++) dur[i] = 12;
    run_frame("p12_too_fast");
  endtask
  task automatic test_random();
    for (int n = 0; n < 10; n++) begin
      int p, j;
      p = (n % 3 == 0) ? int'($urandom_range(6, 20)) : int'($urandom_range(21, 400));
      j = int'($urandom_range(0, 2));
      for (int i = 0; i < 8; i++) dur[i] = p - j + int'($urandom_range(0, 2 * j));
      run_frame($sformatf("rand%0d_p%0d", n, p));
    end
  endtask
  task automatic test_overflow();
    int n;
    bit seen_e, seen_d;
    pulse_arm("overflow");
    rx = 1'b0;
    n = 0;
    seen_e = 0;
    seen_d = 0;
    while (n < M + 40 && !seen_e) begin
      @(negedge clk);
      n++;
      if (io.err) seen_e = 1;
      if (io.done) seen_d = 1;
    end
    m_code = 1;
    total++;
    if (!seen_e || seen_d) begin
      bad++;
      $display("FAIL overflow pulse: err_seen=%0d done_seen=%0d expected 1 0", seen_e, seen_d);
    end
    total++;
    if (n < M - 2 || n > M + 6) begin
      bad++;
      $display("FAIL overflow timing: %0d cycles expected about %0d", n, M);
    end
    total++;
    if (io.err_code !== 2'b01 || io.baud_val !== 13'(m_bv) || io.baud_val_fraction !== 3'(m_fr)) begin
      bad++;
      $display("FAIL overflow state: code=%b baud=%0d frac=%0d expected 01 %0d %0d", io.err_code, io.baud_val, io.baud_val_fraction, m_bv, m_fr);
    end
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  task automatic test_abort();
    int stray;
    pulse_arm("abort");
    m_code = 0;
    for (int i = 0; i < 5; i++) begin
      rx = (i % 2 == 1) ? 1'b1 : 1'b0;
      repeat (50) @(negedge clk);
    end
    io.abort = 1'b1;
    @(negedge clk) io.abort = 1'b0;
    total++;
    if (io.busy !== 1'b0) begin
      bad++;
      $display("FAIL abort busy: %b expected 0", io.busy);
    end
    stray = (io.done || io.err) ? 1 : 0;
    for (int i = 5; i < 10; i++) begin
      rx = (i % 2 == 1) ? 1'b1 : 1'b0;
      repeat (50) @(negedge clk) if (io.done || io.err || io.busy) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL abort activity: %0d cycles of done/err/busy expected 0", stray);
    end
    total++;
    if (io.baud_val !== 13'(m_bv) || io.baud_val_fraction !== 3'(m_fr) || io.err_code !== 2'(m_code)) begin
      bad++;
      $display("FAIL abort state: baud=%0d frac=%0d code=%b expected %0d %0d %0d", io.baud_val, io.baud_val_fraction, io.err_code, m_bv, m_fr, m_code);
    end
    rx = 1'b1;
    repeat (8) @(negedge clk);
  endtask
  task automatic test_arm_abort_same();
    @(negedge clk) begin
      io.arm = 1'b1;
      io.abort = 1'b1;
    end
    @(negedge clk) begin
      io.arm = 1'b0;
      io.abort = 1'b0;
    end
    total++;
    if (io.busy !== 1'b0) begin
      bad++;
      $display("FAIL arm+abort: busy=%b expected 0", io.busy);
    end
  endtask
`ifdef AUTOBAUD_CHECK_EN
  task automatic test_check();
    for (int i = 0; i < 8; i++) dur[i] = 160;
    dur[3] = 240;
    run_frame("check_stretch");
  endtask
`endif
  initial begin
    io.arm = 1'b0;
    io.abort = 1'b0;
    test_reset();
    test_directed();
    test_arm_abort_same();
    test_random();
    test_abort();
    test_overflow();
`ifdef AUTOBAUD_CHECK_EN
    test_check();
`endif
    for (int i = 0; i < 8; i++) dur[i] = 200;
    run_frame("back_to_back");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
